recursion_step_ctrl: RTL

- Sequencer for one trellis recursion (alpha forward or beta backward) over a frame of up to DEPTH_RAM steps.
- Reads branch metrics from branch-metric RAM. Issues one aligned valid/address per step to the row_calc_service bank.
- Waits for the bank's result valid before the next step, because step k+1 needs row(k+1) fed back.
- Write-enables the state-metric RAM and reports done or error to the SISO top-level control.

---
 rtl/recursion_step_ctrl_pkg.sv | 35 +++
 rtl/recursion_step_ctrl_if.sv | 53 +++++
 rtl/recursion_step_ctrl_delay_line.sv | 45 ++++
 rtl/recursion_step_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/recursion_step_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// recursion_step_ctrl_pkg
//   Shared types and defaults for the trellis recursion sequencer.
//   - state_t        : FSM state encoding (IDLE, READ, ALIGN, WAIT, DONE)
//   - *_DEF          : default frame capacity and pipeline latencies
//   - addr_width()   : address width needed to index a RAM of a given depth
// -----------------------------------------------------------------------------
package recursion_step_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_ALIGN = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Frame capacity in trellis steps.
   localparam int DEPTH_RAM_DEF = 3072;

   // Branch-metric RAM read latency (1..4 supported).
   localparam int RAM_LAT_DEF   = 1;

   // Must stay equal to the row_calc_service pipeline depth (i_valid -> o_valid).
   localparam int CALC_LAT_DEF  = 3;

   // Extra cycles tolerated beyond CALC_LAT before a missing result is an error.
   localparam int TMO_SLACK_DEF = 2;

   // Address width for a RAM of 'depth' words; never narrower than 1 bit.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/recursion_step_ctrl_if.sv
// -----------------------------------------------------------------------------
// recursion_step_ctrl_if
//   Memory and row-calc bus between the recursion sequencer and its datapath.
//   Signal names are given from the sequencer's point of view.
//   - o_bm_ren / o_bm_raddr      : branch-metric RAM read port
//   - o_calc_valid / o_calc_addr : step issue to row_calc_service
//   - o_first                    : step 0 marker (use initial metrics)
//   - i_calc_valid / i_calc_addr : row_calc_service result
//   - o_sm_we / o_sm_waddr       : state-metric RAM write port
//   modport master : the sequencer
//   modport slave  : the datapath (RAMs + row_calc_service)
// -----------------------------------------------------------------------------
interface recursion_step_ctrl_if
   import recursion_step_ctrl_pkg::*;
#(
   parameter int AW = addr_width(DEPTH_RAM_DEF)
) ();

   logic          o_bm_ren;
   logic [AW-1:0] o_bm_raddr;
   logic          o_calc_valid;
   logic [AW-1:0] o_calc_addr;
   logic          o_first;
   logic          i_calc_valid;
   logic [AW-1:0] i_calc_addr;
   logic          o_sm_we;
   logic [AW-1:0] o_sm_waddr;

   modport master (
      output o_bm_ren,
      output o_bm_raddr,
      output o_calc_valid,
      output o_calc_addr,
      output o_first,
      input  i_calc_valid,
      input  i_calc_addr,
      output o_sm_we,
      output o_sm_waddr
   );

   modport slave (
      input  o_bm_ren,
      input  o_bm_raddr,
      input  o_calc_valid,
      input  o_calc_addr,
      input  o_first,
      output i_calc_valid,
      output i_calc_addr,
      input  o_sm_we,
      input  o_sm_waddr
   );

endinterface

// File: rtl/recursion_step_ctrl_delay_line.sv
// -----------------------------------------------------------------------------
// delay_line
//   1-bit shift register of LEN stages with a synchronous flush.
//   Used to line the step-issue pulse up with branch-metric RAM read data.
//   Ports:
//   - aclk    : clock
//   - aresetn : asynchronous active-low reset (all stages cleared)
//   - i_clr   : synchronous flush, drops any pulse in flight
//   - i_d     : input bit
//   - o_q     : i_d delayed by LEN cycles (registered)
// -----------------------------------------------------------------------------
module delay_line #(
   parameter int LEN = 1
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic i_clr,
   input  logic i_d,
   output logic o_q
);

   // w_tap[k] is the input of stage k; w_tap[LEN] is the final stage output.
   logic w_tap [LEN+1];

   assign w_tap[0] = i_d;

   generate
      for (genvar gi = 0; gi < LEN; gi++) begin : g_stage
         logic r_q;

         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               r_q <= 1'b0;
            end else begin
               r_q <= i_clr ? 1'b0 : w_tap[gi];
            end
         end

         assign w_tap[gi+1] = r_q;
      end
   endgenerate

   assign o_q = w_tap[LEN];

endmodule

// File: rtl/recursion_step_ctrl.sv
// -----------------------------------------------------------------------------
// recursion_step_ctrl
//   Sequencer for one trellis recursion (alpha forward / beta backward).
//   Each step: read branch metrics, issue one aligned valid/address to the
//   row_calc_service bank, then wait for its result before the next step
//   (step k+1 consumes row k fed back from the bank).
//
//   Ports:
//   - aclk, aresetn : clock, asynchronous active-low reset
//   - i_start       : start pulse, only looked at in IDLE
//   - i_dir         : 0 = forward (0 up), 1 = backward (len-1 down)
//   - i_len         : frame length in steps (clamped to DEPTH_RAM)
//   - i_abort       : synchronous abort back to IDLE, no done pulse
//   - bus (master)  : branch-metric read, calc issue/result, state-metric write
//   - o_busy        : high outside IDLE
//   - o_done        : one-cycle completion pulse
//   - o_err         : sticky error, cleared by the next accepted start
//
//   Step period is 1 + RAM_LAT + CALC_LAT cycles (READ, ALIGN, WAIT).
// -----------------------------------------------------------------------------
module recursion_step_ctrl
   import recursion_step_ctrl_pkg::*;
#(
   parameter  int DEPTH_RAM = DEPTH_RAM_DEF,
   parameter  int RAM_LAT   = RAM_LAT_DEF,
   parameter  int CALC_LAT  = CALC_LAT_DEF,
   parameter  int TMO_SLACK = TMO_SLACK_DEF,
   localparam int AW        = addr_width(DEPTH_RAM)
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 i_start,
   input  logic                 i_dir,
   input  logic [AW:0]          i_len,
   input  logic                 i_abort,
   recursion_step_ctrl_if.master bus,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err
);

   // Total WAIT cycles allowed before a missing result is flagged.
   localparam int TMO = CALC_LAT + TMO_SLACK;
   localparam int WCW = $clog2(TMO + 1);

   localparam logic [AW:0]    LEN_MAX  = (AW+1)'(DEPTH_RAM);
   localparam logic [WCW-1:0] WCNT_END = WCW'(TMO - 1);

   // ---------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------
   state_t         r_state;
   logic           r_dir;
   logic [AW:0]    r_len;
   logic [AW:0]    r_step;
   logic [AW-1:0]  r_addr;
   logic [WCW-1:0] r_wcnt;
   logic           r_bm_ren;
   logic           r_busy;
   logic           r_done;
   logic           r_err;

   logic [AW:0]    w_len_clamped;
   logic           w_last;
   logic           w_calc_valid;
   logic           w_first;
   logic           w_first_in;

   assign w_len_clamped = (i_len > LEN_MAX) ? LEN_MAX : i_len;

   // Last-step test happens before any address update, so the backward
   // decrement below zero is never taken.
   assign w_last = (r_step == (r_len - 1'b1));

   // ---------------------------------------------------------------------
   // RAM_LAT alignment: the issue pulse is the read strobe delayed by the
   // RAM latency, so it lands on the same cycle as the read data.
   // ---------------------------------------------------------------------
   assign w_first_in = r_bm_ren & (r_step == '0);

   delay_line #(
      .LEN (RAM_LAT)
   ) u_valid_dly (
      .aclk    (aclk),
      .aresetn (aresetn),
      .i_clr   (i_abort),
      .i_d     (r_bm_ren),
      .o_q     (w_calc_valid)
   );

   delay_line #(
      .LEN (RAM_LAT)
   ) u_first_dly (
      .aclk    (aclk),
      .aresetn (aresetn),
      .i_clr   (i_abort),
      .i_d     (w_first_in),
      .o_q     (w_first)
   );

   // ---------------------------------------------------------------------
   // Sequencer FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state  <= S_IDLE;
         r_dir    <= 1'b0;
         r_len    <= '0;
         r_step   <= '0;
         r_addr   <= '0;
         r_wcnt   <= '0;
         r_bm_ren <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         // Single-cycle strobes default low.
         r_bm_ren <= 1'b0;
         r_done   <= 1'b0;

         if (i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     r_dir  <= i_dir;
                     r_len  <= w_len_clamped;
                     r_err  <= 1'b0;
                     r_step <= '0;
                     r_addr <= (i_dir && (w_len_clamped != '0)) ?
                               AW'(w_len_clamped - 1'b1) : '0;
                     // A zero-length frame still passes through READ, but
                     // without the read strobe; it then goes to DONE.
                     r_bm_ren <= (w_len_clamped != '0);
                     r_busy   <= 1'b1;
                     r_state  <= S_READ;
                  end
               end

               S_READ: begin
                  if (r_len == '0) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_ALIGN;
                  end
               end

               S_ALIGN: begin
                  // Leave on the cycle the aligned issue pulse is on the bus.
                  if (w_calc_valid) begin
                     r_wcnt  <= '0;
                     r_state <= S_WAIT;
                  end
               end

               S_WAIT: begin
                  if (bus.i_calc_valid) begin
                     if (bus.i_calc_addr != r_addr) begin
                        r_err <= 1'b1;
                     end
                     if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end else begin
                        r_step   <= r_step + 1'b1;
                        r_addr   <= r_dir ? (r_addr - 1'b1) : (r_addr + 1'b1);
                        r_bm_ren <= 1'b1;
                        r_state  <= S_READ;
                     end
                  end else if (r_wcnt == WCNT_END) begin
                     // CALC_LAT + TMO_SLACK cycles in WAIT with no result.
                     r_err   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_wcnt <= r_wcnt + 1'b1;
                  end
               end

               S_DONE: begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end

               default: begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   // The step address only moves on WAIT -> READ, so the same register
   // serves as read address and issue address.
   assign bus.o_bm_ren     = r_bm_ren;
   assign bus.o_bm_raddr   = r_addr;
   assign bus.o_calc_valid = w_calc_valid;
   assign bus.o_calc_addr  = r_addr;
   assign bus.o_first      = w_first;

   // Results are written only while waiting for them; an abort in the same
   // cycle wins and suppresses the write.
   assign bus.o_sm_we      = bus.i_calc_valid & (r_state == S_WAIT) & ~i_abort;
   assign bus.o_sm_waddr   = bus.i_calc_addr;

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_err  = r_err;

endmodule
